// File: rtl/gen_gamma_decoder.sv
// Gamma (keystream) decoder: subtracts an internal LCG keystream from the
// (SIZE+1)-bit ciphertext and registers the low SIZE bits as plaintext.
module gen_gamma_decoder #(
  parameter int unsigned SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set0,
  input  logic            set1,
  input  logic [SIZE:0]   md,
  input  logic [SIZE-1:0] nk,
  output logic [SIZE-1:0] od
);

  localparam int unsigned MW = SIZE + 1;

  logic [SIZE-1:0] r_gamma;
  logic [SIZE-1:0] r_inc;
  logic [SIZE-1:0] r_od;

  logic [SIZE-1:0] w_gamma_nxt;
  logic [SIZE-1:0] w_inc_nxt;
  logic [SIZE-1:0] w_od_nxt;
  logic [SIZE-1:0] w_plain;
  logic [SIZE-1:0] w_lcg;

  // Full-width subtraction; the ciphertext MSB only feeds the borrow chain
  assign w_plain = SIZE'(md - MW'({1'b0, r_gamma}));

  // gamma*5 + inc, carries out of SIZE bits discarded
  assign w_lcg = (r_gamma << 2) + r_gamma + r_inc;

  // Next-state selection: run beats load, otherwise hold
  always_comb begin
    w_gamma_nxt = r_gamma;
    w_inc_nxt   = r_inc;
    w_od_nxt    = r_od;
    if (set1) begin
      w_od_nxt    = w_plain;
      w_gamma_nxt = w_lcg;
    end else if (set0) begin
      w_gamma_nxt = nk;
      w_inc_nxt   = {nk[SIZE-1:1], 1'b1};
      w_od_nxt    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gamma <= '0;
      r_inc   <= SIZE'(1);
      r_od    <= '0;
    end else begin
      r_gamma <= w_gamma_nxt;
      r_inc   <= w_inc_nxt;
      r_od    <= w_od_nxt;
    end
  end

  assign od = r_od;

endmodule

// File: tb/tb_gen_gamma_decoder.sv
// Directed + randomized bench for gen_gamma_decoder against an arithmetic
// model of the keystream generator and the subtraction.
module tb_gen_gamma_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       set0 = 1'b0;
  logic       set1 = 1'b0;
  logic [8:0] md = '0;
  logic [7:0] nk = '0;
  logic [7:0] od;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state, plain integers mod 256
  int m_gamma = 0;
  int m_inc   = 1;
  int m_od    = 0;

  gen_gamma_decoder #(.SIZE(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .set0 (set0),
    .set1 (set1),
    .md   (md),
    .nk   (nk),
    .od   (od)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_tests++;
    assert (obs === 32'(exp)) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one clock edge and advance the model from the inputs seen there
  task automatic cyc();
    int n_g, n_i, n_o;
    n_g = m_gamma; n_i = m_inc; n_o = m_od;
    if (set1) begin
      n_o = ((int'(md) - m_gamma) % 256 + 256) % 256;
      n_g = (5 * m_gamma + m_inc) % 256;
    end else if (set0) begin
      n_g = int'(nk);
      n_i = int'(nk) | 1;
      n_o = 0;
    end
    @(posedge clk);
    #1;
    m_gamma = n_g; m_inc = n_i; m_od = n_o;
  endtask

  task automatic model_reset();
    m_gamma = 0; m_inc = 1; m_od = 0;
  endtask

  initial begin
    int         ref_od[6];
    logic [8:0] mds[6];
    logic [7:0] gh[300];
    logic [255:0] seen;
    int         data;
    int         distinct;

    // Asynchronous reset with random inputs, no clock edge yet
    md = 9'($urandom); nk = 8'($urandom);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("reset_async_od", 32'(od), 0);
    chk("reset_gamma", 32'(dut.r_gamma), 0);
    chk("reset_inc", 32'(dut.r_inc), 1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(); cyc();
    chk("idle_after_reset_od", 32'(od), 0);

    // Load then run
    nk = 8'h24; set0 = 1'b1;
    cyc();
    chk("load_gamma", 32'(dut.r_gamma), 8'h24);
    chk("load_inc", 32'(dut.r_inc), 8'h25);
    chk("load_od", 32'(od), 0);
    set0 = 1'b0; set1 = 1'b1; md = 9'h130;
    cyc();
    chk("run_edge1_od", 32'(od), 8'h0C);
    chk("run_edge1_model", 32'(od), m_od);
    chk("run_edge1_gamma", 32'(dut.r_gamma), 8'hD9);
    cyc();
    chk("run_edge2_od", 32'(od), 8'h57);
    chk("run_edge2_gamma", 32'(dut.r_gamma), 8'h62);

    // Priority: reload to reach gamma=0xD9, then set0 and set1 together
    set1 = 1'b0; set0 = 1'b1; nk = 8'h24;
    cyc();
    set0 = 1'b0; set1 = 1'b1; md = 9'h130;
    cyc();
    set0 = 1'b1; md = 9'h005;
    cyc();
    chk("prio_od_wrap", 32'(od), 8'h2C);
    chk("prio_gamma", 32'(dut.r_gamma), m_gamma);
    chk("prio_gamma_const", 32'(dut.r_gamma), (5 * 8'hD9 + 8'h25) % 256);

    // Idle holds everything
    set0 = 1'b0; set1 = 1'b0; md = 9'($urandom); nk = 8'($urandom);
    cyc();
    chk("idle_od", 32'(od), m_od);
    chk("idle_gamma", 32'(dut.r_gamma), m_gamma);

    // Key isolation: same run twice, second with nk disturbed mid-run
    for (int k = 0; k < 6; k++) mds[k] = 9'($urandom);
    nk = 8'h24; set0 = 1'b1;
    cyc();
    set0 = 1'b0; set1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      md = mds[k];
      cyc();
      ref_od[k] = m_od;
      chk("key_ref_od", 32'(od), m_od);
    end
    set1 = 1'b0; set0 = 1'b1; nk = 8'h24;
    cyc();
    set0 = 1'b0; set1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      md = mds[k];
      if (k == 3) nk = 8'hFF;
      cyc();
      chk("key_iso_od", 32'(od), ref_od[k]);
    end

    // Roundtrip against the encoder's full-width sum
    set1 = 1'b0; set0 = 1'b1; nk = 8'h81;
    cyc();
    set0 = 1'b0; set1 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      data = int'($urandom_range(0, 255));
      md = 9'(data + m_gamma);
      nk = 8'($urandom);
      cyc();
      gh[i] = dut.r_gamma;
      if (32'(od) !== 32'(data) || 32'(gh[i]) !== 32'(m_gamma))
        chk("roundtrip_od", 32'(od), data);
      else
        n_tests++;
    end
    chk("roundtrip_final_gamma", 32'(dut.r_gamma), m_gamma);
    seen = '0;
    for (int i = 0; i < 256; i++) seen[gh[i]] = 1'b1;
    distinct = 0;
    for (int i = 0; i < 256; i++) if (seen[i]) distinct++;
    chk("period_distinct", 32'(distinct), 256);
    for (int i = 0; i < 44; i++)
      chk("period_repeat", 32'(gh[i + 256]), int'(gh[i]));

    // Reset mid-run
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrun_reset_od", 32'(od), 0);
    chk("midrun_reset_gamma", 32'(dut.r_gamma), 0);
    set1 = 1'b0;
    #2 rst_n = 1'b1;
    set1 = 1'b1; md = 9'h0AB;
    cyc();
    chk("after_reset_od", 32'(od), 8'hAB);
    chk("after_reset_gamma", 32'(dut.r_gamma), 8'h01);
    chk("after_reset_model", 32'(od), m_od);
    set1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
